// File: rtl/fft_sample_buffer.sv
// fft_sample_buffer: ping-pong N-point frame buffer draining first-stage radix-4 groups {x[g], x[g+N/4], x[g+N/2], x[g+3N/4]}
module fft_sample_buffer #(
    parameter int WIDTH = 32,
    parameter int N     = 16,
    localparam int HW   = WIDTH / 2,
    localparam int Q    = N / 4,
    localparam int GW   = (Q > 1) ? $clog2(Q) : 1,
    localparam int PW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [HW-1:0]    sample_in,
    input  logic             sample_valid,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [GW-1:0]    group_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_last,
    output logic             overflow
);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_e;
    bank_e         st_q [2];
    bank_e         st_d [2];
    logic [HW-1:0] mem_q [2][N];
    logic [HW-1:0] grp_q [4];
    logic [HW-1:0] grp_d [4];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [GW-1:0] rd_g_q, rd_g_d, gidx_q, gidx_d;
    logic          fill_sel_q, fill_sel_d, drain_sel_q, drain_sel_d, out_bank_q, out_bank_d;
    logic          valid_q, valid_d, last_q, last_d, ovf_q, ovf_d;
    logic          fill_ok, wr_en, wr_last, xfer, load, rd_last;
    assign fill_ok = (st_q[fill_sel_q] == EMPTY) || (st_q[fill_sel_q] == FILLING);
    assign wr_en   = sample_valid && fill_ok;
    assign wr_last = wptr_q == PW'(N - 1);
    assign xfer    = valid_q && out_ready;
    assign load    = (!valid_q || out_ready) && ((st_q[drain_sel_q] == FULL) || (st_q[drain_sel_q] == DRAINING));
    assign rd_last = rd_g_q == GW'(Q - 1);
    always_comb begin
        st_d        = st_q;
        wptr_d      = wptr_q;
        fill_sel_d  = fill_sel_q;
        drain_sel_d = drain_sel_q;
        rd_g_d      = rd_g_q;
        grp_d       = grp_q;
        gidx_d      = gidx_q;
        out_bank_d  = out_bank_q;
        valid_d     = valid_q;
        last_d      = last_q;
        ovf_d       = ovf_q || (sample_valid && !fill_ok);
        if (xfer && last_q)
            st_d[out_bank_q] = EMPTY;
        if (wr_en) begin
            st_d[fill_sel_q] = wr_last ? FULL : FILLING;
            wptr_d           = wptr_q + PW'(1);
            fill_sel_d       = wr_last ? !fill_sel_q : fill_sel_q;
        end
        if (load) begin
            for (int k = 0; k < 4; k++)
                grp_d[k] = mem_q[drain_sel_q][PW'(k * Q) + PW'(rd_g_q)];
            st_d[drain_sel_q] = DRAINING;
            gidx_d            = rd_g_q;
            last_d            = rd_last;
            out_bank_d        = drain_sel_q;
            valid_d           = 1'b1;
            rd_g_d            = rd_last ? '0 : rd_g_q + GW'(1);
            drain_sel_d       = rd_last ? !drain_sel_q : drain_sel_q;
        end else if (xfer) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[fill_sel_q][wptr_q] <= sample_in;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= '{EMPTY, EMPTY};
            wptr_q      <= '0;
            fill_sel_q  <= 1'b0;
            drain_sel_q <= 1'b0;
            rd_g_q      <= '0;
            grp_q       <= '{default: '0};
            gidx_q      <= '0;
            out_bank_q  <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            st_q        <= st_d;
            wptr_q      <= wptr_d;
            fill_sel_q  <= fill_sel_d;
            drain_sel_q <= drain_sel_d;
            rd_g_q      <= rd_g_d;
            grp_q       <= grp_d;
            gidx_q      <= gidx_d;
            out_bank_q  <= out_bank_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            ovf_q       <= ovf_d;
        end
    end
    assign a          = {grp_q[0], {HW{1'b0}}};
    assign b          = {grp_q[1], {HW{1'b0}}};
    assign c          = {grp_q[2], {HW{1'b0}}};
    assign d          = {grp_q[3], {HW{1'b0}}};
    assign group_idx  = gidx_q;
    assign out_valid  = valid_q;
    assign frame_last = last_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_fft_sample_buffer.sv
// tb_fft_sample_buffer: directed scenario tests for fft_sample_buffer (N=16, WIDTH=32)
module tb_fft_sample_buffer;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [1:0]  g;
        logic        fl;
    } grp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a, b, c, d;
    logic [1:0]  group_idx;
    logic        out_valid, frame_last, overflow;
    grp_t        cur;
    grp_t        mon_q[$];
    int          tests = 0;
    int          fails = 0;
    fft_sample_buffer #(.WIDTH(32), .N(16)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .a(a), .b(b), .c(c), .d(d), .group_idx(group_idx), .out_valid(out_valid),
        .out_ready(out_ready), .frame_last(frame_last), .overflow(overflow)
    );
    always #5 clk = ~clk;
    assign cur = {a, b, c, d, group_idx, frame_last};
    always @(negedge clk)
        if (!rst && out_valid && out_ready)
            mon_q.push_back(cur);
    function automatic logic [31:0] w(input int s);
        return {16'(s), 16'h0};
    endfunction
    function automatic grp_t eg(input int base, input int step, input int g);
        grp_t r;
        r.a  = w(base + step * g);
        r.b  = w(base + step * (g + 4));
        r.c  = w(base + step * (g + 8));
        r.d  = w(base + step * (g + 12));
        r.g  = 2'(g);
        r.fl = (g == 3);
        return r;
    endfunction
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic feed(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_in    = 16'(base + i);
            tick();
        end
        sample_valid = 1'b0;
    endtask
    task automatic wait_group(input int g, input string name);
        int t = 0;
        while (!(out_valid && group_idx == 2'(g)) && t < 40) begin
            tick();
            t++;
        end
        tests++;
        if (t >= 40) begin
            fails++;
            $display("FAIL %s timeout: g%0d never presented within 40 cycles", name, g);
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        tests++;
        if ({out_valid, frame_last, overflow, group_idx} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 00000", {out_valid, frame_last, overflow, group_idx});
        end
        tests++;
        if ({a, b, c, d} !== 128'b0) begin
            fails++;
            $display("FAIL reset_data got %h want 0", {a, b, c, d});
        end
        rst = 1'b0;
        tick();
    endtask
    task automatic test_basic();
        mon_q.delete();
        out_ready = 1'b1;
        feed(1, 16);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_latency_early got out_valid=%b want 0", out_valid);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || cur !== eg(1, 1, 0)) begin
            fails++;
            $display("FAIL basic_g0 got v=%b %h want v=1 %h", out_valid, cur, eg(1, 1, 0));
        end
        tick(3);
        tests++;
        if (out_valid !== 1'b1 || cur !== eg(1, 1, 3)) begin
            fails++;
            $display("FAIL basic_g3 got v=%b %h want v=1 %h", out_valid, cur, eg(1, 1, 3));
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_end got out_valid=%b want 0", out_valid);
        end
        tests++;
        if (mon_q.size() != 4) begin
            fails++;
            $display("FAIL basic_count got %0d want 4", mon_q.size());
        end
        for (int i = 0; i < mon_q.size() && i < 4; i++) begin
            tests++;
            if (mon_q[i] !== eg(1, 1, i)) begin
                fails++;
                $display("FAIL basic_seq[%0d] got %h want %h", i, mon_q[i], eg(1, 1, i));
            end
        end
    endtask
    task automatic test_backpressure();
        mon_q.delete();
        out_ready = 1'b1;
        feed(50, 16);
        wait_group(1, "bp_wait");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || cur !== eg(50, 1, 1)) begin
                fails++;
                $display("FAIL bp_hold[%0d] got v=%b %h want v=1 %h", i, out_valid, cur, eg(50, 1, 1));
            end
        end
        out_ready = 1'b1;
        tick(5);
        tests++;
        if (mon_q.size() != 4) begin
            fails++;
            $display("FAIL bp_count got %0d want 4", mon_q.size());
        end
        for (int i = 0; i < mon_q.size() && i < 4; i++) begin
            tests++;
            if (mon_q[i] !== eg(50, 1, i)) begin
                fails++;
                $display("FAIL bp_seq[%0d] got %h want %h", i, mon_q[i], eg(50, 1, i));
            end
        end
    endtask
    task automatic test_sign_gaps();
        mon_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            sample_valid = (i % 2 == 0);
            sample_in    = 16'h8000;
            tick();
        end
        sample_valid = 1'b0;
        tick(8);
        tests++;
        if (mon_q.size() != 4 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL sign_count got %0d ovf=%b want 4 ovf=0", mon_q.size(), overflow);
        end
        for (int i = 0; i < mon_q.size() && i < 4; i++) begin
            tests++;
            if (mon_q[i] !== eg(32'h8000, 0, i)) begin
                fails++;
                $display("FAIL sign_seq[%0d] got %h want %h", i, mon_q[i], eg(32'h8000, 0, i));
            end
        end
    endtask
    task automatic test_overflow();
        int bases[3] = '{0, 16, 100};
        mon_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sample_valid = 1'b1;
            sample_in    = 16'(i);
            tick();
            if (i == 31 || i == 32) begin
                tests++;
                if (overflow !== (i == 32)) begin
                    fails++;
                    $display("FAIL ovf_after_%0d got %b want %b", i + 1, overflow, i == 32);
                end
            end
        end
        sample_valid = 1'b0;
        out_ready = 1'b1;
        tick(6);
        feed(100, 16);
        tick(10);
        tests++;
        if (mon_q.size() != 12 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_count got %0d ovf=%b want 12 ovf=1", mon_q.size(), overflow);
        end
        for (int i = 0; i < mon_q.size() && i < 12; i++) begin
            tests++;
            if (mon_q[i] !== eg(bases[i / 4], 1, i % 4)) begin
                fails++;
                $display("FAIL ovf_seq[%0d] got %h want %h", i, mon_q[i], eg(bases[i / 4], 1, i % 4));
            end
        end
    endtask
    task automatic test_streaming();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mon_q.delete();
        out_ready = 1'b1;
        feed(200, 64);
        tick(8);
        tests++;
        if (mon_q.size() != 16 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL stream_count got %0d ovf=%b want 16 ovf=0", mon_q.size(), overflow);
        end
        for (int i = 0; i < mon_q.size() && i < 16; i++) begin
            tests++;
            if (mon_q[i] !== eg(200 + 16 * (i / 4), 1, i % 4)) begin
                fails++;
                $display("FAIL stream_seq[%0d] got %h want %h", i, mon_q[i], eg(200 + 16 * (i / 4), 1, i % 4));
            end
        end
    endtask
    task automatic test_reset_mid();
        out_ready = 1'b0;
        feed(300, 40);
        out_ready = 1'b1;
        wait_group(2, "rstmid_wait");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_state got v=%b ovf=%b want 0 0", out_valid, overflow);
        end
        mon_q.delete();
        feed(400, 16);
        tick(8);
        tests++;
        if (mon_q.size() != 4) begin
            fails++;
            $display("FAIL rstmid_count got %0d want 4", mon_q.size());
        end
        for (int i = 0; i < mon_q.size() && i < 4; i++) begin
            tests++;
            if (mon_q[i] !== eg(400, 1, i)) begin
                fails++;
                $display("FAIL rstmid_seq[%0d] got %h want %h", i, mon_q[i], eg(400, 1, i));
            end
        end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_sign_gaps();
        test_overflow();
        test_streaming();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
